riscv_imem_loader: RTL and testbench

Boot-time program loader that writes the single-cycle RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive word-aligned byte addresses starting at 0x0. It verifies a trailing 8-bit checksum and holds the core in reset until a load completes cleanly. It sits between the host link (UART/debug receiver) and the instruction memory write port.

---
 rtl/riscv_imem_loader.sv | 140 ++++++++++++++
 tb/tb_riscv_imem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_loader.sv
// Boot-time instruction memory loader: byte stream in, 32-bit words out.
// Verifies a trailing 8-bit checksum and gates the core reset on success.
module riscv_imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH+1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_core_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [ADDR_WIDTH:0]   words_inc;
  logic [ADDR_WIDTH:0]   clamped;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            idx_q;
  logic [7:0]            sum_q;
  logic                  err_q;
  logic                  core_rst_q;
  logic                  done_q;
  logic                  rdy;
  logic                  xfer;
  logic                  can_start;
  logic                  sum_bad;

  assign clamped = (i_word_count > MAX_WORDS) ? MAX_WORDS
                                              : i_word_count;
  assign words_inc = words_q + (ADDR_WIDTH+1)'(1);

  // Ready is a pure function of state, never of i_byte_valid.
  assign rdy  = (state == S_RECV) || (state == S_CHECK);
  assign xfer = rdy && i_byte_valid;

  assign can_start = i_start &&
                     ((state == S_IDLE) || (state == S_DONE));
  assign sum_bad   = (i_byte != sum_q);

  assign o_byte_ready = rdy;
  assign o_imem_we    = (state == S_WRITE);
  assign o_busy       = (state == S_RECV) || (state == S_WRITE) ||
                        (state == S_CHECK);
  assign o_imem_addr  = {waddr_q, 2'b00};
  assign o_imem_wdata = wdata_q;
  assign o_core_rst   = core_rst_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (i_start)
          state_nx = (clamped == '0) ? S_CHECK : S_RECV;
      end
      S_RECV: begin
        if (xfer && idx_q == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = (words_inc == count_q) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        if (xfer) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: word assembly, address, checksum and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      words_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (can_start) begin
        count_q    <= clamped;
        words_q    <= '0;
        waddr_q    <= '0;
        idx_q      <= '0;
        sum_q      <= '0;
        err_q      <= 1'b0;
        core_rst_q <= 1'b1;
      end
      if (state == S_RECV && xfer) begin
        wdata_q[{idx_q, 3'b000} +: 8] <= i_byte;
        idx_q <= idx_q + 2'd1;
        sum_q <= sum_q + i_byte;
      end
      if (state == S_WRITE) begin
        waddr_q <= waddr_q + ADDR_WIDTH'(1);
        words_q <= words_inc;
      end
      if (state == S_CHECK && xfer) begin
        err_q      <= sum_bad;
        core_rst_q <= sum_bad;
        done_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Bench for riscv_imem_loader: directed and randomized loads
// compared against a stream-level model of expected memory writes.
module tb_riscv_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW+1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          i_rst;
  logic          i_start;
  logic [AW:0]   i_word_count;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_imem_we;
  logic [AW+1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_core_rst;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  wr_t        got[$];
  int         done_cnt = 0;
  int         overlap = 0;
  logic [7:0] stream[$];

  riscv_imem_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_rst   (o_core_rst),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (o_imem_we) got.push_back('{o_imem_addr, o_imem_wdata});
    if (o_done) done_cnt++;
    if (o_imem_we && o_byte_ready) overlap++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_words(input int cnt);
    return (cnt > DEPTH) ? DEPTH : cnt;
  endfunction

  // Random payload for the effective word count plus checksum byte.
  task automatic make_stream(input int cnt, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    stream.delete();
    sum = 8'h00;
    for (int k = 0; k < 4 * eff_words(cnt); k++) begin
      b = 8'($urandom);
      stream.push_back(b);
      sum = sum + b;
    end
    if (bad) sum = sum ^ 8'($urandom_range(1, 255));
    stream.push_back(sum);
  endtask

  task automatic run_load(input int cnt, input int gap_pct,
                          input int restart_cyc,
                          output int lat, output bit tmo);
    int i;
    int cyc;
    @(negedge clk);
    i_start = 1'b1;
    i_word_count = (AW+1)'(cnt);
    i = 0;
    cyc = 0;
    tmo = 1'b0;
    lat = -1;
    forever begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      if (o_done) begin
        lat = cyc;
        break;
      end
      if (cyc > 600) begin
        tmo = 1'b1;
        break;
      end
      if (cyc == restart_cyc) begin
        i_start = 1'b1;
        i_word_count = '0;
      end
      if (i < stream.size() &&
          int'($urandom_range(0, 99)) >= gap_pct) begin
        i_byte_valid = 1'b1;
        i_byte = stream[i];
        if (o_byte_ready) i++;
      end else begin
        i_byte_valid = 1'b0;
        i_byte = 8'($urandom);
      end
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic check_load(input string tag, input int cnt,
                            input bit bad, input int gap_pct,
                            input int restart_cyc);
    int lat;
    bit tmo;
    int n;
    int wbase;
    int dbase;
    int obase;
    n = eff_words(cnt);
    wbase = got.size();
    dbase = done_cnt;
    obase = overlap;
    run_load(cnt, gap_pct, restart_cyc, lat, tmo);
    check({tag, "_timeout"}, 64'(tmo), 64'(0));
    if (gap_pct == 0) check({tag, "_latency"}, 64'(lat), 64'(5 * n + 2));
    check({tag, "_nwrites"}, 64'(got.size() - wbase), 64'(n));
    for (int w = 0; w < n && wbase + w < got.size(); w++) begin
      check($sformatf("%s_addr%0d", tag, w),
            64'(got[wbase + w].addr), 64'(4 * w));
      check($sformatf("%s_data%0d", tag, w),
            64'(got[wbase + w].data),
            64'({stream[4*w+3], stream[4*w+2],
                 stream[4*w+1], stream[4*w]}));
    end
    check({tag, "_err"}, 64'(o_err), 64'(bad));
    check({tag, "_core_rst"}, 64'(o_core_rst), 64'(bad));
    check({tag, "_done_hi"}, 64'(o_done), 64'(1));
    check({tag, "_busy_done"}, 64'(o_busy), 64'(0));
    @(negedge clk);
    check({tag, "_done_lo"}, 64'(o_done), 64'(0));
    check({tag, "_done_cnt"}, 64'(done_cnt - dbase), 64'(1));
    check({tag, "_err_held"}, 64'(o_err), 64'(bad));
    check({tag, "_we_rdy"}, 64'(overlap - obase), 64'(0));
  endtask

  initial begin
    int k;
    int cyc;
    int cnt;
    bit bad;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_word_count = '0;
    i_byte_valid = 1'b0;
    i_byte = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_core_rst", 64'(o_core_rst), 64'(1));
    check("rst_ready", 64'(o_byte_ready), 64'(0));
    check("rst_we", 64'(o_imem_we), 64'(0));
    check("rst_addr", 64'(o_imem_addr), 64'(0));
    check("rst_wdata", 64'(o_imem_wdata), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(o_byte_ready), 64'(0));
    check("idle_core_rst", 64'(o_core_rst), 64'(1));

    stream = '{8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    check_load("two_word", 2, 1'b0, 0, -1);

    stream[8] = 8'h00;
    check_load("bad_sum", 2, 1'b1, 0, -1);

    make_stream(3, 1'b0);
    check_load("gaps", 3, 1'b0, 50, -1);

    make_stream(2, 1'b0);
    check_load("restart_ign", 2, 1'b0, 0, 2);

    make_stream(7, 1'b0);
    check_load("clamp7", 7, 1'b0, 0, -1);
    check("clamp7_addr_wrap", 64'(o_imem_addr), 64'(0));

    make_stream(0, 1'b0);
    check_load("zero", 0, 1'b0, 0, -1);

    make_stream(2, 1'b0);
    k = got.size();
    @(negedge clk);
    i_start = 1'b1;
    i_word_count = (AW+1)'(2);
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      if (k + 6 <= got.size() + 5 && stream.size() > 0) begin
      end
      break;
    end
    k = 0;
    while (k < 6 && cyc < 50) begin
      i_byte_valid = 1'b1;
      i_byte = stream[k];
      if (o_byte_ready) k++;
      @(negedge clk);
      cyc++;
    end
    i_byte_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("mid_timeout", 64'(cyc < 50), 64'(1));
    check("mid_core_rst", 64'(o_core_rst), 64'(1));
    check("mid_ready", 64'(o_byte_ready), 64'(0));
    check("mid_we", 64'(o_imem_we), 64'(0));
    check("mid_addr", 64'(o_imem_addr), 64'(0));
    check("mid_wdata", 64'(o_imem_wdata), 64'(0));
    check("mid_busy", 64'(o_busy), 64'(0));
    check("mid_err", 64'(o_err), 64'(0));
    check("mid_word0",
          64'(got[got.size() - 1].data),
          64'({stream[3], stream[2], stream[1], stream[0]}));
    k = got.size();
    repeat (3) @(negedge clk);
    check("mid_no_write", 64'(got.size() - k), 64'(0));

    make_stream(1, 1'b0);
    check_load("fresh", 1, 1'b0, 0, -1);

    for (int t = 0; t < 8; t++) begin
      cnt = int'($urandom_range(0, 7));
      bad = 1'($urandom_range(0, 1));
      make_stream(cnt, bad);
      check_load($sformatf("rnd%0d", t), cnt, bad,
                 (t % 2 == 0) ? 0 : 40, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
